// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl -- whack-a-mole round sequencer
//
// Decodes PS/2 scan bytes into START / PAUSE / WHACK commands and runs the
// round FSM (IDLE / PLAY / PAUSE / OVER). While playing, it schedules mole
// spawn and show windows from the random source and judges whacks against
// the hammer position. It also owns the score and the countdown. All outputs
// are registered and feed pixel_gen directly.
//
// Ports
//   clk         in   1        system clock
//   reset       in   1        synchronous, active-high
//   tick        in   1        game-time enable, one clk wide
//   kb_valid    in   1        one-clk strobe: new PS/2 byte on kb_code
//   kb_code     in   8        PS/2 scan byte
//   rnd         in   2        random hole index, sampled at spawn
//   hammer_pos  in   2        current hammer hole
//   state       out  2        00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//   mole_on     out  1        mole visible
//   mole_pos    out  2        mole hole
//   hit         out  1        one-clk pulse, successful whack
//   miss        out  1        one-clk pulse, wasted whack
//   score       out  SCORE_W  hits this round, saturating
//   time_left   out  6        seconds remaining
//
// Build option
//   SPEEDUP_EN  when defined, the show window shrinks by 2 ticks for every
//               4 points scored, with MIN_MOLE_TICKS as the floor. The window
//               is sampled when the mole spawns. Otherwise the window is
//               always MOLE_TICKS.
// -----------------------------------------------------------------------------
module game_ctrl #(
    parameter int TICKS_PER_SEC  = 60,
    parameter int GAME_SECS      = 30,
    parameter int MOLE_TICKS     = 45,
    parameter int GAP_TICKS      = 15,
    parameter int MIN_MOLE_TICKS = 15,
    parameter int SCORE_W        = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               kb_valid,
    input  logic [7:0]         kb_code,
    input  logic [1:0]         rnd,
    input  logic [1:0]         hammer_pos,
    output logic [1:0]         state,
    output logic               mole_on,
    output logic [1:0]         mole_pos,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [5:0]         time_left
);

    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_START = 8'h5A;
    localparam logic [7:0] KEY_PAUSE = 8'h76;
    localparam logic [7:0] KEY_WHACK = 8'h29;

    localparam int SEC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int WIN_W = $clog2(MOLE_TICKS + 1);

    localparam logic [SEC_W-1:0]   SEC_LAST  = SEC_W'(TICKS_PER_SEC - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_TICKS - 1);
    localparam logic [5:0]         SECS_INIT = 6'(GAME_SECS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

`ifdef SPEEDUP_EN
    localparam bit SPEEDUP_ON = 1'b1;
`else
    localparam bit SPEEDUP_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    typedef enum logic {
        PH_GAP  = 1'b0,
        PH_SHOW = 1'b1
    } phase_t;

    state_t             state_q,     state_d;
    phase_t             phase_q,     phase_d;
    logic               brk_q,       brk_d;
    logic               mole_on_q,   mole_on_d;
    logic [1:0]         mole_pos_q,  mole_pos_d;
    logic               hit_q,       hit_d;
    logic               miss_q,      miss_d;
    logic [SCORE_W-1:0] score_q,     score_d;
    logic [5:0]         time_left_q, time_left_d;
    logic [SEC_W-1:0]   sec_cnt_q,   sec_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q,   win_cnt_d;
    logic [WIN_W-1:0]   window_q,    window_d;

    logic               key_start, key_pause, key_whack;
    logic [WIN_W-1:0]   spawn_win;
    logic               whack_hits;

    // Show window for a mole spawned at the given score.
    function automatic logic [WIN_W-1:0] speedup_window(input logic [SCORE_W-1:0] s);
        int w;
        w = MOLE_TICKS - 2 * int'(s >> 2);
        if (w < MIN_MOLE_TICKS) begin
            w = MIN_MOLE_TICKS;
        end
        return WIN_W'(w);
    endfunction

    assign spawn_win  = SPEEDUP_ON ? speedup_window(score_q) : WIN_W'(MOLE_TICKS);
    assign whack_hits = mole_on_q && (hammer_pos == mole_pos_q);

    // Key decode. The byte after a break prefix is the release of some key
    // and is dropped along with the prefix, whatever its value.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        brk_d     = brk_q;
        key_start = 1'b0;
        key_pause = 1'b0;
        key_whack = 1'b0;
        if (kb_valid) begin
            if (brk_q) begin
                brk_d = 1'b0;
            end else if (kb_code == KEY_BREAK) begin
                brk_d = 1'b1;
            end else begin
                key_start = (kb_code == KEY_START);
                key_pause = (kb_code == KEY_PAUSE);
                key_whack = (kb_code == KEY_WHACK);
            end
        end
    end

    // Round FSM, mole scheduler, countdown and whack judge.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        mole_on_d   = mole_on_q;
        mole_pos_d  = mole_pos_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        score_d     = score_q;
        time_left_d = time_left_q;
        sec_cnt_d   = sec_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        win_cnt_d   = win_cnt_q;
        window_d    = window_q;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (key_start) begin
                    state_d     = ST_PLAY;
                    score_d     = '0;
                    time_left_d = SECS_INIT;
                    sec_cnt_d   = '0;
                    phase_d     = PH_GAP;
                    gap_cnt_d   = '0;
                    win_cnt_d   = '0;
                    mole_on_d   = 1'b0;
                end
            end

            ST_PLAY: begin
                if (tick) begin
                    if (phase_q == PH_GAP) begin
                        if (gap_cnt_q == GAP_LAST) begin
                            mole_pos_d = rnd;
                            mole_on_d  = 1'b1;
                            phase_d    = PH_SHOW;
                            win_cnt_d  = '0;
                            window_d   = spawn_win;
                        end else begin
                            gap_cnt_d = gap_cnt_q + GAP_W'(1);
                        end
                    end else begin
                        if (win_cnt_q == window_q - WIN_W'(1)) begin
                            mole_on_d = 1'b0;
                            phase_d   = PH_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            win_cnt_d = win_cnt_q + WIN_W'(1);
                        end
                    end

                    if (sec_cnt_q == SEC_LAST) begin
                        sec_cnt_d   = '0;
                        time_left_d = time_left_q - 6'd1;
                        if (time_left_q == 6'd1) begin
                            state_d   = ST_OVER;
                            mole_on_d = 1'b0;
                        end
                    end else begin
                        sec_cnt_d = sec_cnt_q + SEC_W'(1);
                    end
                end

                // Judged on the pre-edge mole, after the tick logic, so a
                // hit wins over a window expiry or the final tick that
                // lands on the same edge.
                if (key_whack) begin
                    if (whack_hits) begin
                        hit_d     = 1'b1;
                        score_d   = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
                        mole_on_d = 1'b0;
                        phase_d   = PH_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        miss_d = 1'b1;
                    end
                end

                // The round ending on this edge takes priority over a pause.
                if (key_pause && state_d == ST_PLAY) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (key_pause) begin
                    state_d = ST_PLAY;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_GAP;
            brk_q       <= 1'b0;
            mole_on_q   <= 1'b0;
            mole_pos_q  <= 2'd0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            score_q     <= '0;
            time_left_q <= SECS_INIT;
            sec_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            win_cnt_q   <= '0;
            window_q    <= WIN_W'(MOLE_TICKS);
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            brk_q       <= brk_d;
            mole_on_q   <= mole_on_d;
            mole_pos_q  <= mole_pos_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            score_q     <= score_d;
            time_left_q <= time_left_d;
            sec_cnt_q   <= sec_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            win_cnt_q   <= win_cnt_d;
            window_q    <= window_d;
        end
    end

    assign state     = state_q;
    assign mole_on   = mole_on_q;
    assign mole_pos  = mole_pos_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign score     = score_q;
    assign time_left = time_left_q;

endmodule

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl -- self-checking bench for game_ctrl (default build).
//
// Directed rounds with a scoreboard: the expected hit/miss outcome of each
// whack and the expected hole of each spawn are queued when the stimulus is
// driven, and monitors pop and compare them when the DUT produces the event.
// Inputs change #1 after the rising edge; outputs are read #1 after the edge
// or on the falling edge.
// -----------------------------------------------------------------------------
module tb_game_ctrl;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam logic [1:0] EXP_HIT  = 2'b10;
    localparam logic [1:0] EXP_MISS = 2'b01;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       kb_valid;
    logic [7:0] kb_code;
    logic [1:0] rnd;
    logic [1:0] hammer_pos;
    logic [1:0] state;
    logic       mole_on;
    logic [1:0] mole_pos;
    logic       hit;
    logic       miss;
    logic [4:0] score;
    logic [5:0] time_left;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] whack_q[$];
    logic [1:0] spawn_q[$];
    logic       spawn_watch = 1'b0;
    logic       mole_on_prev = 1'b0;

    game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .kb_valid   (kb_valid),
        .kb_code    (kb_code),
        .rnd        (rnd),
        .hammer_pos (hammer_pos),
        .state      (state),
        .mole_on    (mole_on),
        .mole_pos   (mole_pos),
        .hit        (hit),
        .miss       (miss),
        .score      (score),
        .time_left  (time_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock with the given inputs presented at the rising edge.
    task automatic cycle(input logic t, input logic kv, input logic [7:0] code);
        tick     = t;
        kb_valid = kv;
        kb_code  = code;
        @(posedge clk);
        #1;
        tick     = 1'b0;
        kb_valid = 1'b0;
        kb_code  = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] code);
        cycle(1'b0, 1'b1, code);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
        end
    endtask

    // Whack outcome monitor: every hit/miss pulse must match the next queued
    // expectation; a pulse lasting two clocks finds the queue empty.
    always @(negedge clk) begin
        if (!reset && (hit || miss)) begin
            check("hit_miss_exclusive", {31'd0, hit & miss}, 32'd0);
            if (whack_q.size() > 0) begin
                check("whack_result", {30'd0, hit, miss}, {30'd0, whack_q.pop_front()});
            end else begin
                check("unexpected_pulse", {30'd0, hit, miss}, 32'd0);
            end
        end
    end

    // Spawn monitor: each rising mole_on must show the queued hole.
    always @(negedge clk) begin
        if (!reset && spawn_watch && mole_on && !mole_on_prev) begin
            if (spawn_q.size() > 0) begin
                check("spawn_pos", {30'd0, mole_pos}, {30'd0, spawn_q.pop_front()});
            end else begin
                check("unexpected_spawn", {31'd0, mole_on}, 32'd0);
            end
        end
        mole_on_prev <= mole_on;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        tick       = 1'b0;
        kb_valid   = 1'b0;
        kb_code    = 8'h00;
        rnd        = 2'd0;
        hammer_pos = 2'd0;

        // Reset state, then a long idle stretch with no keys.
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        check("rst_state",     {30'd0, state},    {30'd0, ST_IDLE});
        check("rst_mole_on",   {31'd0, mole_on},  32'd0);
        check("rst_mole_pos",  {30'd0, mole_pos}, 32'd0);
        check("rst_hit_miss",  {30'd0, hit, miss}, 32'd0);
        check("rst_score",     {27'd0, score},    32'd0);
        check("rst_time_left", {26'd0, time_left}, 32'd30);
        ticks(1000);
        check("idle_state",     {30'd0, state},    {30'd0, ST_IDLE});
        check("idle_mole_on",   {31'd0, mole_on},  32'd0);
        check("idle_score",     {27'd0, score},    32'd0);
        check("idle_time_left", {26'd0, time_left}, 32'd30);

        // Break-prefixed START is dropped; a plain START begins the round.
        spawn_watch = 1'b1;
        send_byte(8'hF0);
        send_byte(8'h5A);
        check("brk_start_ignored", {30'd0, state}, {30'd0, ST_IDLE});
        send_byte(8'h5A);
        check("start_state",     {30'd0, state},     {30'd0, ST_PLAY});
        check("start_time_left", {26'd0, time_left}, 32'd30);
        rnd = 2'd2;
        ticks(14);
        check("gap_14_mole_off", {31'd0, mole_on}, 32'd0);
        spawn_q.push_back(2'd2);
        ticks(1);                                   // tick 15
        rnd = 2'd3;
        check("spawn_mole_on",  {31'd0, mole_on},  32'd1);
        check("spawn_mole_pos", {30'd0, mole_pos}, 32'd2);

        // Hit on the right hole, then a wasted whack on the empty field.
        hammer_pos = 2'd2;
        whack_q.push_back(EXP_HIT);
        send_byte(8'h29);
        check("hit_pulse",   {31'd0, hit},     32'd1);
        check("hit_score",   {27'd0, score},   32'd1);
        check("hit_mole_off", {31'd0, mole_on}, 32'd0);
        cycle(1'b0, 1'b0, 8'h00);
        check("hit_one_clk", {31'd0, hit}, 32'd0);
        whack_q.push_back(EXP_MISS);
        send_byte(8'h29);
        check("miss_pulse", {31'd0, miss},  32'd1);
        check("miss_score", {27'd0, score}, 32'd1);

        // Wrong hole: miss and the mole stays; then window expiry and respawn.
        rnd = 2'd2;
        spawn_q.push_back(2'd2);
        ticks(15);                                  // tick 30
        hammer_pos = 2'd1;
        whack_q.push_back(EXP_MISS);
        send_byte(8'h29);
        check("wrong_hole_miss",    {31'd0, miss},    32'd1);
        check("wrong_hole_mole_on", {31'd0, mole_on}, 32'd1);
        ticks(44);                                  // tick 74
        check("window_44_on", {31'd0, mole_on}, 32'd1);
        ticks(1);                                   // tick 75
        check("window_45_off", {31'd0, mole_on}, 32'd0);
        rnd = 2'd1;
        spawn_q.push_back(2'd1);
        ticks(14);                                  // tick 89
        check("respawn_14_off", {31'd0, mole_on}, 32'd0);
        ticks(1);                                   // tick 90
        check("respawn_on",    {31'd0, mole_on},   32'd1);
        check("time_left_90",  {26'd0, time_left}, 32'd29);

        // Pause mid-show: ticks and whacks have no effect until resumed.
        ticks(10);                                  // tick 100
        send_byte(8'h76);
        check("pause_state", {30'd0, state}, {30'd0, ST_PAUSE});
        ticks(200);
        hammer_pos = 2'd1;
        send_byte(8'h29);
        check("pause_no_pulse", {30'd0, hit, miss}, 32'd0);
        check("pause_state2",   {30'd0, state},     {30'd0, ST_PAUSE});
        check("pause_mole_on",  {31'd0, mole_on},   32'd1);
        check("pause_mole_pos", {30'd0, mole_pos},  32'd1);
        check("pause_time",     {26'd0, time_left}, 32'd29);
        check("pause_score",    {27'd0, score},     32'd1);
        send_byte(8'h5A);
        check("pause_start_ignored", {30'd0, state}, {30'd0, ST_PAUSE});
        send_byte(8'h76);
        check("resume_state", {30'd0, state}, {30'd0, ST_PLAY});
        ticks(19);                                  // tick 119
        check("resume_time_119", {26'd0, time_left}, 32'd29);
        ticks(1);                                   // tick 120
        check("resume_time_120", {26'd0, time_left}, 32'd28);
        ticks(14);                                  // tick 134
        check("resume_win_on",  {31'd0, mole_on}, 32'd1);
        ticks(1);                                   // tick 135
        check("resume_win_off", {31'd0, mole_on}, 32'd0);

        // Run to the end; the mole spawned at tick 1770 is hit on tick 1800.
        spawn_watch = 1'b0;
        rnd        = 2'd3;
        hammer_pos = 2'd3;
        ticks(1664);                                // tick 1799
        check("pre_end_state",    {30'd0, state},     {30'd0, ST_PLAY});
        check("pre_end_time",     {26'd0, time_left}, 32'd1);
        check("pre_end_mole_on",  {31'd0, mole_on},   32'd1);
        check("pre_end_mole_pos", {30'd0, mole_pos},  32'd3);
        whack_q.push_back(EXP_HIT);
        cycle(1'b1, 1'b1, 8'h29);                   // tick 1800 + whack
        check("end_state",   {30'd0, state},     {30'd0, ST_OVER});
        check("end_time",    {26'd0, time_left}, 32'd0);
        check("end_hit",     {31'd0, hit},       32'd1);
        check("end_score",   {27'd0, score},     32'd2);
        check("end_mole_on", {31'd0, mole_on},   32'd0);
        ticks(100);
        send_byte(8'h29);
        send_byte(8'h76);
        check("over_state",   {30'd0, state},     {30'd0, ST_OVER});
        check("over_score",   {27'd0, score},     32'd2);
        check("over_time",    {26'd0, time_left}, 32'd0);
        check("over_mole_on", {31'd0, mole_on},   32'd0);

        // Second round: 40 hits saturate the score at 31.
        send_byte(8'h5A);
        check("restart_state", {30'd0, state},     {30'd0, ST_PLAY});
        check("restart_score", {27'd0, score},     32'd0);
        check("restart_time",  {26'd0, time_left}, 32'd30);
        spawn_watch = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rnd        = 2'(i % 4);
            hammer_pos = 2'(i % 4);
            spawn_q.push_back(2'(i % 4));
            ticks(15);
            whack_q.push_back(EXP_HIT);
            send_byte(8'h29);
            check("sat_score", {27'd0, score}, (i + 1 > 31) ? 32'd31 : 32'(i + 1));
        end
        check("sat_time", {26'd0, time_left}, 32'd20);

        // Hit on the same tick the window expires: the hit still counts.
        rnd        = 2'd1;
        hammer_pos = 2'd1;
        spawn_q.push_back(2'd1);
        ticks(15);
        ticks(44);
        check("exp_pre_on", {31'd0, mole_on}, 32'd1);
        whack_q.push_back(EXP_HIT);
        cycle(1'b1, 1'b1, 8'h29);
        check("exp_hit",     {31'd0, hit},     32'd1);
        check("exp_mole_off", {31'd0, mole_on}, 32'd0);
        check("exp_score",   {27'd0, score},   32'd31);
        spawn_q.push_back(2'd1);
        ticks(14);
        check("exp_gap_off", {31'd0, mole_on}, 32'd0);
        ticks(1);
        check("exp_respawn", {31'd0, mole_on}, 32'd1);
        send_byte(8'h5A);
        check("play_start_ignored", {27'd0, score}, 32'd31);

        // Reset from the middle of a round.
        reset = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        check("mid_rst_state",   {30'd0, state},     {30'd0, ST_IDLE});
        check("mid_rst_mole_on", {31'd0, mole_on},   32'd0);
        check("mid_rst_score",   {27'd0, score},     32'd0);
        check("mid_rst_time",    {26'd0, time_left}, 32'd30);
        cycle(1'b0, 1'b0, 8'h00);

        check("whack_q_drained", 32'(whack_q.size()), 32'd0);
        check("spawn_q_drained", 32'(spawn_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
